sram_port_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single on-chip SRAM s1 slave port (8-bit word address, 32-bit data)

---
 rtl/sram_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sram_port_arbiter : round-robin sharing of one SRAM s1 port by NUM_REQ
// requesters. Optional macro: SRAM_ARB_FIXED_PRI0_EN (requester 0 absolute).
// Revision: 1.0
// ============================================================================
module sram_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int RD_LAT  = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      arb_en,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*AW-1:0]     req_addr,
   input  logic [NUM_REQ*DW-1:0]     req_wdata,
   input  logic [NUM_REQ*DW/8-1:0]   req_be,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DW-1:0]             rsp_rdata,
   output logic [AW-1:0]             sram_address,
   output logic                      sram_clken,
   output logic                      sram_chipselect,
   output logic                      sram_write,
   output logic [DW-1:0]             sram_writedata,
   output logic [DW/8-1:0]           sram_byteenable,
   input  logic [DW-1:0]             sram_readdata
);
   localparam int BW  = DW / 8;
   localparam int IDW = $clog2(NUM_REQ);

   logic [IDW-1:0]              rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]              win, win_next;
   logic                        found, hs;
   logic [NUM_REQ-1:0]          grant;
   logic [AW-1:0]               sram_address_q, sram_address_d;
   logic [DW-1:0]               sram_writedata_q, sram_writedata_d;
   logic [BW-1:0]               sram_byteenable_q, sram_byteenable_d;
   logic                        sram_chipselect_q, sram_chipselect_d;
   logic                        sram_write_q, sram_write_d;
   logic                        sram_clken_q, sram_clken_d;
   logic [IDW-1:0]              issue_id_q, issue_id_d;
   logic [RD_LAT-1:0]           tag_vld_q, tag_vld_d;
   logic [RD_LAT-1:0][IDW-1:0]  tag_id_q, tag_id_d;

   // Scan starts at rr_ptr and wraps; with fixed priority, index 0 is
   // excluded from the rotation and overrides it instead.
   always_comb begin : grant_scan
      int             idx;
      logic [IDW-1:0] idx_sel;
      idx     = 0;
      idx_sel = '0;
      win     = '0;
      found   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_sel = IDW'(idx);
`ifdef SRAM_ARB_FIXED_PRI0_EN
         if (!found && idx_sel != '0 && req_valid[idx_sel]) begin
`else
         if (!found && req_valid[idx_sel]) begin
`endif
            found = 1'b1;
            win   = idx_sel;
         end
      end
`ifdef SRAM_ARB_FIXED_PRI0_EN
      if (req_valid[0]) begin
         found = 1'b1;
         win   = '0;
      end
`endif
   end

   assign grant     = (found && arb_en && !reset) ? (NUM_REQ'(1) << win) : '0;
   assign hs        = |grant;
   assign req_ready = grant;
   assign win_next  = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
`ifdef SRAM_ARB_FIXED_PRI0_EN
      if (hs && win != '0) rr_ptr_d = win_next;
`else
      if (hs) rr_ptr_d = win_next;
`endif
   end

   always_comb begin
      sram_address_d    = sram_address_q;
      sram_writedata_d  = sram_writedata_q;
      sram_byteenable_d = sram_byteenable_q;
      issue_id_d        = issue_id_q;
      sram_chipselect_d = 1'b0;
      sram_write_d      = 1'b0;
      sram_clken_d      = 1'b1;
      if (hs) begin
         sram_chipselect_d = 1'b1;
         sram_write_d      = req_write[win];
         sram_address_d    = req_addr[win*AW +: AW];
         sram_writedata_d  = req_wdata[win*DW +: DW];
         sram_byteenable_d = req_be[win*BW +: BW];
         issue_id_d        = win;
      end
   end

   // Stage 0 is loaded at the end of the chipselect cycle, so the last
   // stage lines up with sram_readdata RD_LAT cycles later.
   always_comb begin
      tag_vld_d    = tag_vld_q;
      tag_id_d     = tag_id_q;
      tag_vld_d[0] = sram_chipselect_q & ~sram_write_q;
      tag_id_d[0]  = issue_id_q;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q          <= '0;
         sram_address_q    <= '0;
         sram_writedata_q  <= '0;
         sram_byteenable_q <= '0;
         sram_chipselect_q <= 1'b0;
         sram_write_q      <= 1'b0;
         sram_clken_q      <= 1'b0;
         issue_id_q        <= '0;
         tag_vld_q         <= '0;
         tag_id_q          <= '0;
      end else begin
         rr_ptr_q          <= rr_ptr_d;
         sram_address_q    <= sram_address_d;
         sram_writedata_q  <= sram_writedata_d;
         sram_byteenable_q <= sram_byteenable_d;
         sram_chipselect_q <= sram_chipselect_d;
         sram_write_q      <= sram_write_d;
         sram_clken_q      <= sram_clken_d;
         issue_id_q        <= issue_id_d;
         tag_vld_q         <= tag_vld_d;
         tag_id_q          <= tag_id_d;
      end
   end

   assign rsp_valid = (tag_vld_q[RD_LAT-1] && !reset) ? (NUM_REQ'(1) << tag_id_q[RD_LAT-1]) : '0;
   assign rsp_rdata = (tag_vld_q[RD_LAT-1] && !reset) ? sram_readdata : '0;

   assign sram_address    = sram_address_q;
   assign sram_writedata  = sram_writedata_q;
   assign sram_byteenable = sram_byteenable_q;
   assign sram_chipselect = sram_chipselect_q;
   assign sram_write      = sram_write_q;
   assign sram_clken      = sram_clken_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_port_arbiter : directed bench with SRAM model and response scoreboard.
// Revision: 1.0
// ============================================================================
module tb_sram_port_arbiter;
   localparam int N   = 4;
   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int BW  = DW / 8;
   localparam int LAT = 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              arb_en = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_write = '0;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_wdata = '0;
   logic [N*BW-1:0]   req_be = '0;
   logic [N-1:0]      req_ready, rsp_valid;
   logic [DW-1:0]     rsp_rdata, sram_writedata, sram_readdata;
   logic [AW-1:0]     sram_address;
   logic              sram_clken, sram_chipselect, sram_write;
   logic [BW-1:0]     sram_byteenable;

   always #5 clk = ~clk;

   sram_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .arb_en(arb_en),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .sram_address(sram_address), .sram_clken(sram_clken),
      .sram_chipselect(sram_chipselect), .sram_write(sram_write),
      .sram_writedata(sram_writedata), .sram_byteenable(sram_byteenable),
      .sram_readdata(sram_readdata)
   );

   // SRAM s1 model, readdata one cycle after the chipselect cycle
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_q;
   assign sram_readdata = rd_q;
   always @(posedge clk) begin
      if (sram_chipselect && sram_clken) begin
         if (sram_write) begin
            for (int i = 0; i < BW; i++)
               if (sram_byteenable[i]) mem[sram_address][8*i +: 8] <= sram_writedata[8*i +: 8];
         end else begin
            rd_q <= mem[sram_address];
         end
      end
   end

   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          q[$];
   logic [DW-1:0] gold [256];
   int            n_asrt = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            ptr = 0;
   bit            hold_valid = 1'b0;
   bit            known = 1'b0;
   logic          e_cs, e_we, e_clk;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wd;
   logic [BW-1:0] e_be;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p, input logic en);
      int idx;
      if (!en) return -1;
`ifdef SRAM_ARB_FIXED_PRI0_EN
      if (v[0]) return 0;
`endif
      for (int k = 0; k < N; k++) begin
         idx = (p + k) % N;
`ifdef SRAM_ARB_FIXED_PRI0_EN
         if (idx == 0) continue;
`endif
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic set_req(input int id, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
      req_valid[id]            = 1'b1;
      req_write[id]            = wr;
      req_addr[id*AW +: AW]    = a;
      req_wdata[id*DW +: DW]   = d;
      req_be[id*BW +: BW]      = b;
   endtask

   // One clock cycle: check outputs at the falling edge, then advance the model.
   task automatic step();
      int            w;
      rsp_t          e;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [BW-1:0] b;
      @(negedge clk);
      if (reset) q.delete();
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << e.id));
         chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
      end else begin
         chk("rsp_idle", 64'(rsp_valid), 64'(0));
      end
      if (known) begin
         chk("sram_cs",    64'(sram_chipselect), 64'(e_cs));
         chk("sram_write", 64'(sram_write),      64'(e_we));
         chk("sram_clken", 64'(sram_clken),      64'(e_clk));
         chk("sram_addr",  64'(sram_address),    64'(e_addr));
         chk("sram_wdata", 64'(sram_writedata),  64'(e_wd));
         chk("sram_be",    64'(sram_byteenable), 64'(e_be));
      end
      w = reset ? -1 : pick(req_valid, ptr, arb_en);
      chk("req_ready", 64'(req_ready), (w < 0) ? 64'(0) : 64'(N'(1) << w));
      if (reset) begin
         ptr = 0; e_cs = 0; e_we = 0; e_clk = 0; e_addr = '0; e_wd = '0; e_be = '0;
         known = 1'b1;
      end else begin
         e_clk = 1'b1;
         if (w >= 0) begin
            a = req_addr[w*AW +: AW];
            d = req_wdata[w*DW +: DW];
            b = req_be[w*BW +: BW];
            e_cs = 1'b1; e_we = req_write[w]; e_addr = a; e_wd = d; e_be = b;
            if (req_write[w]) begin
               for (int i = 0; i < BW; i++)
                  if (b[i]) gold[a][8*i +: 8] = d[8*i +: 8];
            end else begin
               q.push_back('{due: cyc + 1 + LAT, id: w, data: gold[a]});
            end
`ifdef SRAM_ARB_FIXED_PRI0_EN
            if (w != 0) ptr = (w + 1) % N;
`else
            ptr = (w + 1) % N;
`endif
         end else begin
            e_cs = 1'b0;
            e_we = 1'b0;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (w >= 0 && !hold_valid) req_valid[w] = 1'b0;
   endtask

   initial begin
      reset = 1'b1; arb_en = 1'b0;
      step(); step();
      reset = 1'b0; arb_en = 1'b1;
      step();
      // single write then read-back by another requester
      set_req(2, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF); step();
      step();
      set_req(1, 1'b0, 8'h10, 32'h0, 4'h0); step();
      step(); step();
      // preload locations used later
      set_req(0, 1'b1, 8'h20, 32'h12345678, 4'hF); step();
      set_req(3, 1'b1, 8'h30, 32'hCAFEF00D, 4'hF); step();
      set_req(1, 1'b1, 8'h31, 32'h0BADC0DE, 4'hF); step();
      // reset arrives while a read is in flight
      set_req(3, 1'b0, 8'h20, 32'h0, 4'h0); step();
      step();
      reset = 1'b1; step();
      reset = 1'b0;
      set_req(3, 1'b0, 8'h31, 32'h0, 4'h0);
      set_req(2, 1'b0, 8'h30, 32'h0, 4'h0);
      step(); step(); step();
      // all four valid continuously, partial-byte write followed by same-address read
      hold_valid = 1'b1;
      set_req(0, 1'b1, 8'h30, 32'h11115A5A, 4'h3);
      set_req(1, 1'b0, 8'h30, 32'h0, 4'h0);
      set_req(2, 1'b0, 8'h10, 32'h0, 4'h0);
      set_req(3, 1'b0, 8'h31, 32'h0, 4'h0);
      repeat (8) step();
      // grants stop, in-flight reads still return
      arb_en = 1'b0;
      repeat (4) step();
      req_valid = '0; hold_valid = 1'b0; arb_en = 1'b1;
      step(); step();
      // requester 0 valid every cycle, then dropped
      hold_valid = 1'b1;
      set_req(0, 1'b0, 8'h10, 32'h0, 4'h0);
      set_req(1, 1'b0, 8'h20, 32'h0, 4'h0);
      set_req(2, 1'b0, 8'h30, 32'h0, 4'h0);
      set_req(3, 1'b0, 8'h31, 32'h0, 4'h0);
      repeat (4) step();
      req_valid[0] = 1'b0;
      repeat (3) step();
      req_valid = '0; hold_valid = 1'b0;
      repeat (3) step();
      chk("drain", 64'(q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
